// File: rtl/pipeline_writeback_pkg.sv
// Shared constants and pending-entry type for the writeback stage.
// Optional feature: WB_BYPASS_EN enables read bypass from pending writes.
package pipeline_writeback_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;
  localparam int WB_DEPTH = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] result;
  } wb_entry_t;

endpackage

// File: rtl/pipeline_writeback_wb_fifo.sv
// Two-entry in-order pending-write buffer.
// ent0 is always the oldest entry; both entries are visible for bypass.
module wb_fifo
  import pipeline_writeback_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t ent0,
  output wb_entry_t ent1,
  output logic      vld0,
  output logic      vld1
);

  wb_entry_t  ent0_q, ent0_d;
  wb_entry_t  ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] cnt_after;
  logic       push_ok;
  logic       pop_ok;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign vld0  = (cnt_q != 2'd0);
  assign vld1  = (cnt_q == 2'd2);
  assign ent0  = ent0_q;
  assign ent1  = ent1_q;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pop shifts the younger entry forward; push fills the first free slot.
  always_comb begin
    ent0_d    = ent0_q;
    ent1_d    = ent1_q;
    cnt_after = cnt_q - {1'b0, pop_ok};
    if (pop_ok) begin
      ent0_d = ent1_q;
    end
    if (push_ok) begin
      if (cnt_after == 2'd0) begin
        ent0_d = din;
      end else begin
        ent1_d = din;
      end
    end
    cnt_d = cnt_after + {1'b0, push_ok};
  end

  // Buffer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_writeback.sv
// Writeback stage: buffers execute results and commits them to the regfile.
// Define WB_BYPASS_EN to let reads see pending (uncommitted) results.
module pipeline_writeback #(
  parameter int DATA_W = pipeline_writeback_pkg::DATA_W,
  parameter int ADDR_W = pipeline_writeback_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic [DATA_W-1:0] ex_result,
  output logic              ex_ready,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [7:0]        retire_count
);

  import pipeline_writeback_pkg::*;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [7:0]        ret_q, ret_d;

  wb_entry_t in_ent;
  wb_entry_t ent0;
  wb_entry_t ent1;
  logic      full;
  logic      empty;
  logic      vld0;
  logic      vld1;
  logic      push;
  logic      pop;

  assign ex_ready     = ~full;
  assign push         = ex_valid & ~full;
  assign pop          = wb_en & ~empty;
  assign in_ent       = '{dest: ex_dest, result: ex_result};
  assign retire_count = ret_q;

  wb_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_ent),
    .full  (full),
    .empty (empty),
    .ent0  (ent0),
    .ent1  (ent1),
    .vld0  (vld0),
    .vld1  (vld1)
  );

  // Commit the oldest pending entry when the write slot is granted.
  always_comb begin
    rf_d  = rf_q;
    ret_d = ret_q;
    if (pop) begin
      rf_d[ent0.dest] = ent0.result;
      ret_d           = ret_q + 8'd1;
    end
  end

  // Register file and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q  <= '{default: '0};
      ret_q <= 8'd0;
    end else begin
      rf_q  <= rf_d;
      ret_q <= ret_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Newest matching pending entry overrides the register file.
  always_comb begin
    rd_data_a = rf_q[rd_addr_a];
    rd_data_b = rf_q[rd_addr_b];
    if (vld0 && ent0.dest == rd_addr_a) rd_data_a = ent0.result;
    if (vld1 && ent1.dest == rd_addr_a) rd_data_a = ent1.result;
    if (vld0 && ent0.dest == rd_addr_b) rd_data_b = ent0.result;
    if (vld1 && ent1.dest == rd_addr_b) rd_data_b = ent1.result;
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{ent1, vld0, vld1};

  // Reads see committed state only.
  always_comb begin
    rd_data_a = rf_q[rd_addr_a];
    rd_data_b = rf_q[rd_addr_b];
  end
`endif

endmodule

// File: tb/tb_pipeline_writeback.sv
// Randomized bench for pipeline_writeback with a queue-based reference model.
// Honours WB_BYPASS_EN the same way the design does.
module tb_pipeline_writeback;

  logic       clk;
  logic       rst;
  logic       ex_valid;
  logic [3:0] ex_dest;
  logic [7:0] ex_result;
  logic       ex_ready;
  logic       wb_en;
  logic [3:0] rd_addr_a;
  logic [3:0] rd_addr_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic [7:0] retire_count;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 0;

  typedef struct {
    logic [3:0] dest;
    logic [7:0] res;
  } m_ent_t;

  m_ent_t     m_q[$];
  logic [7:0] m_regs [16];
  logic [7:0] m_ret;

  pipeline_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_dest      (ex_dest),
    .ex_result    (ex_result),
    .ex_ready     (ex_ready),
    .wb_en        (wb_en),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .retire_count (retire_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [3:0] a);
    logic [7:0] v;
    v = m_regs[a];
`ifdef WB_BYPASS_EN
    foreach (m_q[i]) if (m_q[i].dest == a) v = m_q[i].res;
`endif
    return v;
  endfunction

  // Reference model: in-order queue of at most two pending writes.
  bit do_push, do_pop;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_ret = 8'h00;
    end else begin
      do_push = ex_valid && (m_q.size() < 2);
      do_pop  = wb_en && (m_q.size() > 0);
      if (do_pop) begin
        m_regs[m_q[0].dest] = m_q[0].res;
        void'(m_q.pop_front());
        m_ret = m_ret + 8'd1;
      end
      if (do_push) m_q.push_back('{dest: ex_dest, res: ex_result});
    end
  end

  // Compare outputs against the model every cycle.
  always @(negedge clk) begin
    if (checking) begin
      chk("ex_ready", {7'b0, ex_ready}, {7'b0, m_q.size() < 2});
      chk("retire_count", retire_count, m_ret);
      chk("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
      chk("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d, input logic [7:0] r);
    ex_valid  = 1;
    ex_dest   = d;
    ex_result = r;
    tick();
  endtask

  logic [7:0] byp;

  initial begin
    rst = 1; ex_valid = 0; ex_dest = 0; ex_result = 0;
    wb_en = 0; rd_addr_a = 0; rd_addr_b = 0;
    repeat (3) tick();
    checking = 1;
    chk("reset_ready", {7'b0, ex_ready}, 8'h01);
    chk("reset_retire", retire_count, 8'h00);
    rst = 0;
    tick();

    // Basic commit
    wb_en = 1;
    push(4'd3, 8'h07);
    ex_valid = 0;
    tick();
    rd_addr_a = 4'd3; #1;
    chk("basic_r3", rd_data_a, 8'h07);
    chk("basic_retire", retire_count, 8'h01);
    wb_en = 0;

    // Full buffer holds a third producer
    push(4'd1, 8'h11);
    push(4'd2, 8'h22);
    ex_valid = 1; ex_dest = 4'd6; ex_result = 8'h66; #1;
    chk("full_ready", {7'b0, ex_ready}, 8'h00);
    tick();
    chk("full_hold", {7'b0, ex_ready}, 8'h00);
    wb_en = 1;
    tick();
    wb_en = 0;
    rd_addr_a = 4'd1; #1;
    chk("full_r1", rd_data_a, 8'h11);
    chk("full_ready_back", {7'b0, ex_ready}, 8'h01);
    tick();
    ex_valid = 0; wb_en = 1;
    repeat (3) tick();
    wb_en = 0;
    rd_addr_a = 4'd6; rd_addr_b = 4'd2; #1;
    chk("full_r6", rd_data_a, 8'h66);
    chk("full_r2", rd_data_b, 8'h22);
    chk("full_retire", retire_count, 8'h04);

    // Bypass of a pending write
    push(4'd4, 8'h0F);
    ex_valid = 0;
    rd_addr_a = 4'd4; #1;
`ifdef WB_BYPASS_EN
    byp = 8'h0F;
`else
    byp = 8'h00;
`endif
    chk("bypass_r4", rd_data_a, byp);
    wb_en = 1;
    tick();
    wb_en = 0; #1;
    chk("bypass_r4_commit", rd_data_a, 8'h0F);

    // Same-dest ordering
    push(4'd5, 8'h0B);
    push(4'd5, 8'hFF);
    ex_valid = 0;
    wb_en = 1;
    tick(); tick();
    wb_en = 0;
    rd_addr_b = 4'd5; #1;
    chk("order_r5", rd_data_b, 8'hFF);
    chk("order_retire", retire_count, 8'h07);

    // Counter wrap: 249 more commits with back-to-back traffic
    wb_en = 1;
    for (int i = 0; i < 250; i++) begin
      ex_valid  = 1;
      ex_dest   = 4'($urandom_range(0, 15));
      ex_result = 8'($urandom);
      tick();
    end
    chk("wrap_retire", retire_count, 8'h00);
    chk("wrap_ready", {7'b0, ex_ready}, 8'h01);

    // Occupancy around full with push and commit together
    wb_en = 0;
    push(4'd7, 8'h77);
    chk("occ_full", {7'b0, ex_ready}, 8'h00);
    wb_en = 1;
    push(4'd8, 8'h88);
    chk("occ_after_commit", {7'b0, ex_ready}, 8'h01);
    push(4'd8, 8'h89);
    chk("occ_steady", {7'b0, ex_ready}, 8'h01);
    ex_valid = 0;
    repeat (2) tick();
    wb_en = 0;

    // Reset mid-traffic with two entries pending
    push(4'd9, 8'h99);
    push(4'd10, 8'hAA);
    ex_valid = 0;
    rst = 1; #1;
    chk("rst_ready", {7'b0, ex_ready}, 8'h01);
    chk("rst_retire", retire_count, 8'h00);
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); #1;
      chk("rst_reg", rd_data_a, 8'h00);
    end
    tick();
    rst = 0; wb_en = 1;
    repeat (2) tick();
    rd_addr_a = 4'd9; rd_addr_b = 4'd10; #1;
    chk("rst_no_commit_a", rd_data_a, 8'h00);
    chk("rst_no_commit_b", rd_data_b, 8'h00);
    chk("rst_no_retire", retire_count, 8'h00);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      ex_valid  = ($urandom_range(0, 3) != 0);
      ex_dest   = 4'($urandom_range(0, 7));
      ex_result = 8'($urandom);
      wb_en     = ($urandom_range(0, 1) == 1);
      rd_addr_a = 4'($urandom_range(0, 7));
      rd_addr_b = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
